// File: rtl/beat_recorder_bank_if.sv
// Key/button inputs and buzzer/status outputs of beat_recorder_bank.
// master drives the keyboard side; slave is the recorder itself.
interface beat_recorder_bank_if #(
    parameter int CODE_W    = 7,
    parameter int NUM_SLOTS = 3
);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [CODE_W-1:0] key_code;
    logic              rec_btn;
    logic              play_btn;
    logic [SW-1:0]     slot_sel;
    logic [CODE_W-1:0] audio_code;
    logic              recording;
    logic              playing;
    logic              done;
    logic              full;

    modport master (
        output key_code, rec_btn, play_btn, slot_sel,
        input  audio_code, recording, playing, done, full
    );

    modport slave (
        input  key_code, rec_btn, play_btn, slot_sel,
        output audio_code, recording, playing, done, full
    );
endinterface

// File: rtl/beat_recorder_bank.sv
// Multi-bank run-length recorder/player for keyboard note codes.
// Entries are {code, dur}; dur counts ticks of TICK_DIV clocks.
module beat_recorder_bank #(
    parameter int NUM_SLOTS = 3,
    parameter int DEPTH     = 64,
    parameter int CODE_W    = 7,
    parameter int DUR_W     = 12,
    parameter int TICK_DIV  = 50000
) (
    input logic clock,
    input logic resetn,
    beat_recorder_bank_if.slave bus
);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(NUM_SLOTS * DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW = CODE_W + DUR_W;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_SCAN,
        S_HOLD,
        S_END
    } state_t;

    state_t            state;
    logic [EW-1:0]     mem [NUM_SLOTS*DEPTH];
    logic [EW-1:0]     rd_data;
    logic [CODE_W-1:0] rd_code;
    logic [DUR_W-1:0]  rd_dur;
    logic [LW-1:0]     len_q [NUM_SLOTS];
    logic [SW-1:0]     slot_q;
    logic [SW-1:0]     sel_eff;
    logic [TW-1:0]     cnt;
    logic              tick;
    logic [LW-1:0]     ptr;
    logic [CODE_W-1:0] hold_code;
    logic [CODE_W-1:0] play_code;
    logic [DUR_W-1:0]  dur;
    logic [DUR_W-1:0]  remain;
    logic              recording_q;
    logic              playing_q;
    logic              done_q;
    logic              full_q;

    logic              rec_chg;
    logic              rec_sat;
    logic              rec_flush;
    logic              last_slot;
    logic              wr_en;
    logic [EW-1:0]     wr_data;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;

    function automatic logic [AW-1:0] addr_of(
        input logic [SW-1:0] s,
        input logic [LW-1:0] i
    );
        return AW'(s) * AW'(DEPTH) + AW'(i[PW-1:0]);
    endfunction

    assign sel_eff = (int'(bus.slot_sel) >= NUM_SLOTS) ? '0 : bus.slot_sel;
    assign tick    = (cnt == TW'(TICK_DIV - 1));
    assign rd_code = rd_data[EW-1:DUR_W];
    assign rd_dur  = rd_data[DUR_W-1:0];

    assign rec_chg   = (bus.key_code != hold_code);
    assign rec_sat   = tick && (dur == DUR_MAX);
    assign rec_flush = (dur != '0) || (hold_code != '0);
    assign last_slot = (ptr == LW'(DEPTH - 1));

    // A saturating write stores dur itself, which is then DUR_MAX.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = {hold_code, dur};
        if (state == S_REC) begin
            if (bus.rec_btn) wr_en = rec_flush;
            else             wr_en = rec_chg || rec_sat;
        end
    end

    // In PLAY the read port runs one entry ahead of the one being held.
    assign wr_addr = addr_of(slot_q, ptr);
    assign rd_addr = (state == S_IDLE) ? addr_of(sel_eff, '0)
                                       : addr_of(slot_q, ptr);

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            slot_q      <= '0;
            cnt         <= '0;
            ptr         <= '0;
            hold_code   <= '0;
            play_code   <= '0;
            dur         <= '0;
            remain      <= '0;
            recording_q <= 1'b0;
            playing_q   <= 1'b0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            full_q <= 1'b0;
            cnt    <= tick ? '0 : cnt + 1'b1;
            unique case (state)
                S_IDLE: begin
                    play_code <= '0;
                    if (bus.rec_btn) begin
                        state       <= S_REC;
                        slot_q      <= sel_eff;
                        ptr         <= '0;
                        dur         <= '0;
                        hold_code   <= '0;
                        cnt         <= '0;
                        recording_q <= 1'b1;
                    end else if (bus.play_btn) begin
                        slot_q <= sel_eff;
                        if (len_q[sel_eff] == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state     <= S_SCAN;
                            ptr       <= LW'(1);
                            cnt       <= '0;
                            playing_q <= 1'b1;
                        end
                    end
                end
                S_REC: begin
                    if (bus.rec_btn) begin
                        len_q[slot_q] <= rec_flush ? ptr + 1'b1 : ptr;
                        state         <= S_IDLE;
                        recording_q   <= 1'b0;
                    end else if (wr_en) begin
                        ptr <= ptr + 1'b1;
                        dur <= '0;
                        if (rec_chg) hold_code <= bus.key_code;
                        if (last_slot) begin
                            len_q[slot_q] <= LW'(DEPTH);
                            full_q        <= 1'b1;
                            state         <= S_IDLE;
                            recording_q   <= 1'b0;
                        end
                    end else if (tick) begin
                        dur <= dur + 1'b1;
                    end
                end
                // rd_data holds entry ptr-1 here
                S_SCAN: begin
                    if (bus.play_btn) begin
                        state     <= S_IDLE;
                        playing_q <= 1'b0;
                    end else if (rd_dur == '0) begin
                        if (ptr == len_q[slot_q]) begin
                            play_code <= '0;
                            done_q    <= 1'b1;
                            state     <= S_END;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end else begin
                        play_code <= rd_code;
                        remain    <= rd_dur;
                        cnt       <= '0;
                        state     <= S_HOLD;
                    end
                end
                // rd_data holds entry ptr (the next one) here
                S_HOLD: begin
                    if (bus.play_btn) begin
                        state     <= S_IDLE;
                        playing_q <= 1'b0;
                    end else if (tick) begin
                        if (remain != DUR_W'(1)) begin
                            remain <= remain - 1'b1;
                        end else if (ptr == len_q[slot_q]) begin
                            play_code <= '0;
                            done_q    <= 1'b1;
                            state     <= S_END;
                        end else begin
                            ptr <= ptr + 1'b1;
                            if (rd_dur == '0) begin
                                state <= S_SCAN;
                            end else begin
                                play_code <= rd_code;
                                remain    <= rd_dur;
                                cnt       <= '0;
                            end
                        end
                    end
                end
                S_END: begin
                    state     <= S_IDLE;
                    playing_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.audio_code = playing_q ? play_code : bus.key_code;
    assign bus.recording  = recording_q;
    assign bus.playing    = playing_q;
    assign bus.done       = done_q;
    assign bus.full       = full_q;
endmodule
